pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Controls the 32-bit program counter register. Drives its write-enable,
//  overwrite select and overwrite target.
//  Sequences boot hold-off, normal increment, stalls, branch/jump/exception
//  redirects (buffered across stalls) and halt. Sits between hazard/branch
//  logic and the PC; also emits a pipeline flush and a stall-cycle counter.
// PARAMETERS
//  WIDTH        32           PC / target width
//  BOOT_CYCLES  2            cycles PC writes are held off after reset (>=1)
//  EXC_VECTOR   32'h00000004 exception redirect target
//  CNT_WIDTH    16           stall_count width
// PORTS
//  clk            in   1          rising-edge clock
//  reset          in   1          synchronous, active-high
//  stall          in   1          hazard unit: hold PC this cycle
//  branch_taken   in   1          taken branch this cycle
//  branch_target  in   WIDTH      branch target
//  jump           in   1          jump/jal/jr this cycle
//  jump_target    in   WIDTH      jump target
//  exception      in   1          exception/overflow trap this cycle
//  halt           in   1          stop fetch until reset
//  pc_we          out  1          PC write enable
//  pc_overwrite   out  1          1 = load pc_target, 0 = PC+1
//  pc_target      out  WIDTH      PC overwrite value
//  flush          out  1          squash younger instrs (same cycle as redirect)
//  busy_boot      out  1          1 while in BOOT
//  halted         out  1          1 in HALT
//  stall_count    out  CNT_WIDTH  saturating count of cycles in STALL
// BEHAVIOUR
//  All regs update on posedge clk; reset is synchronous, active-high and dominant.
//  Reset -> state=BOOT, boot_cnt=0, pend_v=0, pend_tgt=0, stall_count=0.
//  Outputs are combinational from state/regs/inputs.
//  During reset: pc_we=0, pc_overwrite=0, pc_target=0, flush=0.
//  Redirect priority (high->low): exception(EXC_VECTOR) > jump > branch.
//  States (2-bit): BOOT=00, RUN=01, STALL=10, HALT=11.
//  BOOT: pc_we=0, busy_boot=1, inputs ignored; boot_cnt++.
//   Go to RUN after BOOT_CYCLES cycles (first pc_we=1 is cycle BOOT_CYCLES).
//  RUN, priority halt > stall > redirect > none:
//   halt -> HALT, pc_we=0, any redirect dropped.
//   stall -> STALL, pc_we=0. Highest redirect, if any, is latched into pend.
//    No flush yet.
//   redirect -> pc_we=1, pc_overwrite=1, pc_target=winner, flush=1; stay RUN.
//   none -> pc_we=1, pc_overwrite=0 (PC increments).
//  STALL: stall_count++ each cycle (saturates at all-ones).
//   halt -> HALT; pend cleared.
//   stall=1 -> pc_we=0. A new redirect replaces pend only if its priority
//    is >= the pend priority (pend_pri 2 bits: exc=3, jump=2, branch=1).
//   stall=0 -> RUN. pc_we=1. Winner = highest of {exception input, pend,
//    jump input, branch input}; ties go to the pend entry.
//    If winner exists: pc_overwrite=1, pc_target=winner, flush=1.
//    pend cleared.
//  HALT: pc_we=0, halted=1; all inputs ignored; only reset exits.
//  pc_overwrite=1 only when pc_we=1.
//  pc_target=0 when pc_overwrite=0.
//  stall_count is not cleared on leaving STALL; only reset clears it.
//  Reset asserted mid-STALL with pend valid -> pend discarded, BOOT re-entered.
// TESTING
//  1 reset 1 cycle, release, idle: pc_we=0 for 2 cycles, then 1.
//    PC reads 0,0,0,1,2,...; busy_boot falls with first pc_we.
//  2 RUN, branch_taken=1 tgt=0x40 one cycle: same cycle pc_we=1, pc_overwrite=1,
//    pc_target=0x40, flush=1; next cycle increment.
//  3 jump(0x80)+branch(0x40)+exception same RUN cycle: pc_target=0x4, flush=1.
//    Without exception: pc_target=0x80.
//  4 stall 3 cycles; branch 0x40 in cycle1, jump 0x90 in cycle2.
//    pc_we=0 for 3 cycles, then pc_target=0x90, flush=1; stall_count=3.
//  5 stall with pend jump 0x90; exception on the release cycle:
//    pc_target=0x4, pend cleared.
//  6 halt during STALL with pend: pc_we stays 0, halted=1 forever.
//    Then reset -> BOOT, stall_count=0, no redirect is applied.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot hold-off, increment, stall with buffered
// redirect, exception/jump/branch redirect and halt for a 32-bit PC register.
module pc_sequencer #(
  parameter int               WIDTH       = 32,
  parameter int               BOOT_CYCLES = 2,
  parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(32'h0000_0004),
  parameter int               CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [WIDTH-1:0]     branch_target,
  input  logic                 jump,
  input  logic [WIDTH-1:0]     jump_target,
  input  logic                 exception,
  input  logic                 halt,
  output logic                 pc_we,
  output logic                 pc_overwrite,
  output logic [WIDTH-1:0]     pc_target,
  output logic                 flush,
  output logic                 busy_boot,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  localparam logic [1:0] PRI_NONE   = 2'd0;
  localparam logic [1:0] PRI_BRANCH = 2'd1;
  localparam logic [1:0] PRI_JUMP   = 2'd2;
  localparam logic [1:0] PRI_EXC    = 2'd3;

  state_t               state_reg, state_next;
  logic [BW-1:0]        boot_cnt_reg, boot_cnt_next;
  logic                 pend_v_reg, pend_v_next;
  logic [1:0]           pend_pri_reg, pend_pri_next;
  logic [WIDTH-1:0]     pend_tgt_reg, pend_tgt_next;
  logic [CNT_WIDTH-1:0] stall_count_reg, stall_count_next;

  // Highest-priority redirect requested by the inputs this cycle.
  logic                 in_v;
  logic [1:0]           in_pri;
  logic [WIDTH-1:0]     in_tgt;

  always_comb begin
    in_v   = 1'b0;
    in_pri = PRI_NONE;
    in_tgt = '0;
    if (exception) begin
      in_v   = 1'b1;
      in_pri = PRI_EXC;
      in_tgt = EXC_VECTOR;
    end else if (jump) begin
      in_v   = 1'b1;
      in_pri = PRI_JUMP;
      in_tgt = jump_target;
    end else if (branch_taken) begin
      in_v   = 1'b1;
      in_pri = PRI_BRANCH;
      in_tgt = branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= BOOT;
      boot_cnt_reg    <= '0;
      pend_v_reg      <= 1'b0;
      pend_pri_reg    <= PRI_NONE;
      pend_tgt_reg    <= '0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      boot_cnt_reg    <= boot_cnt_next;
      pend_v_reg      <= pend_v_next;
      pend_pri_reg    <= pend_pri_next;
      pend_tgt_reg    <= pend_tgt_next;
      stall_count_reg <= stall_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    boot_cnt_next    = boot_cnt_reg;
    pend_v_next      = pend_v_reg;
    pend_pri_next    = pend_pri_reg;
    pend_tgt_next    = pend_tgt_reg;
    stall_count_next = stall_count_reg;
    pc_we            = 1'b0;
    pc_overwrite     = 1'b0;
    pc_target        = '0;
    flush            = 1'b0;

    case (state_reg)
      BOOT: begin
        boot_cnt_next = boot_cnt_reg + BW'(1);
        if (boot_cnt_reg == BOOT_LAST) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (halt) begin
          state_next = HALT;
        end else if (stall) begin
          // Redirect is parked until the stall releases; no flush yet.
          state_next = STALL;
          if (in_v) begin
            pend_v_next   = 1'b1;
            pend_pri_next = in_pri;
            pend_tgt_next = in_tgt;
          end
        end else begin
          pc_we = 1'b1;
          if (in_v) begin
            pc_overwrite = 1'b1;
            pc_target    = in_tgt;
            flush        = 1'b1;
          end
        end
      end

      STALL: begin
        if (stall_count_reg != {CNT_WIDTH{1'b1}}) begin
          stall_count_next = stall_count_reg + CNT_WIDTH'(1);
        end
        if (halt) begin
          state_next    = HALT;
          pend_v_next   = 1'b0;
          pend_pri_next = PRI_NONE;
          pend_tgt_next = '0;
        end else if (stall) begin
          // Equal priority replaces: the most recent request of a class wins.
          if (in_v && (!pend_v_reg || in_pri >= pend_pri_reg)) begin
            pend_v_next   = 1'b1;
            pend_pri_next = in_pri;
            pend_tgt_next = in_tgt;
          end
        end else begin
          state_next = RUN;
          pc_we      = 1'b1;
          // On release a tie goes to the older, buffered redirect.
          if (pend_v_reg && pend_pri_reg >= in_pri) begin
            pc_overwrite = 1'b1;
            pc_target    = pend_tgt_reg;
            flush        = 1'b1;
          end else if (in_v) begin
            pc_overwrite = 1'b1;
            pc_target    = in_tgt;
            flush        = 1'b1;
          end
          pend_v_next   = 1'b0;
          pend_pri_next = PRI_NONE;
          pend_tgt_next = '0;
        end
      end

      HALT: begin
      end

      default: begin
        state_next = BOOT;
      end
    endcase

    if (reset) begin
      pc_we        = 1'b0;
      pc_overwrite = 1'b0;
      pc_target    = '0;
      flush        = 1'b0;
    end
  end

  assign busy_boot   = (state_reg == BOOT);
  assign halted      = (state_reg == HALT);
  assign stall_count = stall_count_reg;

endmodule
